// File: rtl/bb2_dot_accum_if.sv
// Handshake bundle for the 2x2 product dot-product accumulator:
// product input stream plus the completed-result output port.
interface bb2_dot_accum_if #(
   parameter int ACC_W = 8
);
   logic                    in_valid;
   logic                    in_ready;
   logic [3:0]              in_pp;
   logic                    in_clear;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [ACC_W-1:0] out_acc;
   logic                    out_sat;

   modport master (
      output in_valid, in_pp, in_clear, out_ready,
      input  in_ready, out_valid, out_acc, out_sat
   );

   modport slave (
      input  in_valid, in_pp, in_clear, out_ready,
      output in_ready, out_valid, out_acc, out_sat
   );
endinterface

// File: rtl/bb2_dot_accum.sv
// Saturating dot-product accumulator for 4-bit signed partial products;
// emits one result plus a sticky saturation flag per VEC_LEN accepted beats.
//
// state | meaning
// ACCUM | accepting products, summing into acc
// DONE  | result held on out_acc/out_sat until out_ready
module bb2_dot_accum #(
   parameter int VEC_LEN = 8,
   parameter int CNT_W   = 3,
   parameter int ACC_W   = 8
) (
   input  logic              clock,
   input  logic              reset,
   bb2_dot_accum_if.slave    bus
);

   typedef enum logic {ACCUM, DONE} state_t;

   localparam logic [CNT_W-1:0] LAST    = CNT_W'(VEC_LEN - 1);
   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   state_t           state, state_nxt;
   logic [CNT_W-1:0] count, count_nxt;
   logic [ACC_W-1:0] acc, acc_nxt;
   logic             sat, sat_nxt;
   logic [ACC_W-1:0] out_acc_q, out_acc_nxt;
   logic             out_sat_q, out_sat_nxt;

   logic [ACC_W:0]   sum;
   logic             clamp;
   logic [ACC_W-1:0] sum_clamped;

   // One guard bit: overflow shows as disagreement between the top two bits.
   always_comb begin
      sum         = {acc[ACC_W-1], acc} + {{(ACC_W-3){bus.in_pp[3]}}, bus.in_pp};
      clamp       = sum[ACC_W] ^ sum[ACC_W-1];
      sum_clamped = sum[ACC_W-1:0];
      if (clamp) begin
         sum_clamped = sum[ACC_W] ? ACC_MIN : ACC_MAX;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ACCUM;
         count     <= '0;
         acc       <= '0;
         sat       <= 1'b0;
         out_acc_q <= '0;
         out_sat_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         count     <= count_nxt;
         acc       <= acc_nxt;
         sat       <= sat_nxt;
         out_acc_q <= out_acc_nxt;
         out_sat_q <= out_sat_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      count_nxt   = count;
      acc_nxt     = acc;
      sat_nxt     = sat;
      out_acc_nxt = out_acc_q;
      out_sat_nxt = out_sat_q;
      unique case (state)
         ACCUM: begin
            if (bus.in_clear) begin
               count_nxt = '0;
               acc_nxt   = '0;
               sat_nxt   = 1'b0;
            end else if (bus.in_valid) begin
               acc_nxt = sum_clamped;
               sat_nxt = sat | clamp;
               if (count == LAST) begin
                  out_acc_nxt = sum_clamped;
                  out_sat_nxt = sat | clamp;
                  count_nxt   = '0;
                  state_nxt   = DONE;
               end else begin
                  count_nxt = count + 1'b1;
               end
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               acc_nxt   = '0;
               sat_nxt   = 1'b0;
               state_nxt = ACCUM;
            end
         end
         default: state_nxt = ACCUM;
      endcase
   end

   assign bus.in_ready  = (state == ACCUM);
   assign bus.out_valid = (state == DONE);
   assign bus.out_acc   = out_acc_q;
   assign bus.out_sat   = out_sat_q;

endmodule
